// File: rtl/sound_pkg.sv
// Shared types and default durations for the sound event sequencer.
package sound_pkg;

  // Sequencer states; encoding is fixed so debug probes read consistently.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POINT = 2'd1,
    GAP   = 2'd2,
    LOSE  = 2'd3
  } snd_state_t;

  // Default durations in clk25 cycles (125 ms chirp, 500 ms lose, 50 ms gap).
  localparam int DEF_POINT_CYCLES = 3125000;
  localparam int DEF_LOSE_CYCLES  = 12500000;
  localparam int DEF_GAP_CYCLES   = 1250000;
  localparam int DEF_CNT_W        = 24;

  // Player codes carried on point/lose.
  localparam logic [1:0] P1 = 2'b01;
  localparam logic [1:0] P2 = 2'b10;

endpackage

// File: rtl/sound_dur_timer.sv
// Loadable down-counter that saturates at zero; done flags an expired count.
module sound_dur_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk25,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Load takes precedence; otherwise count down and stop at zero.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (load)       cnt <= value;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/sound_event_seq.sv
// Turns one-cycle score/miss pulses into timed point/lose tone requests,
// with a silent gap between tones and one-deep pending latches per class.
module sound_event_seq
  import sound_pkg::*;
#(
  parameter int POINT_CYCLES = DEF_POINT_CYCLES,
  parameter int LOSE_CYCLES  = DEF_LOSE_CYCLES,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic [1:0] score_evt,
  input  logic [1:0] miss_evt,
  output logic [1:0] point,
  output logic [1:0] lose,
  output logic       busy
);

  // Counter load values; a zero gap never loads, so clamp to avoid underflow.
  localparam logic [CNT_W-1:0] PT_LD  = CNT_W'(POINT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LS_LD  = CNT_W'(LOSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  snd_state_t       state, state_d;
  logic [1:0]       point_q, point_d;
  logic [1:0]       lose_q, lose_d;
  logic [1:0]       pend_pt, pend_pt_d;
  logic [1:0]       pend_ls, pend_ls_d;
  logic             ld;
  logic [CNT_W-1:0] ld_val;
  logic             done;
  logic             go_idle;

  sound_dur_timer #(.CNT_W(CNT_W)) u_timer (
    .clk25 (clk25),
    .rst_n (rst_n),
    .load  (ld),
    .value (ld_val),
    .done  (done)
  );

  // State, tone output and pending-latch registers.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      point_q <= '0;
      lose_q  <= '0;
      pend_pt <= '0;
      pend_ls <= '0;
    end else begin
      state   <= state_d;
      point_q <= point_d;
      lose_q  <= lose_d;
      pend_pt <= pend_pt_d;
      pend_ls <= pend_ls_d;
    end
  end

  // Next state: latch events every cycle, end tones on timer expiry, and
  // pick the next tone (point before lose) whenever the sequencer is free.
  always_comb begin
    state_d   = state;
    point_d   = point_q;
    lose_d    = lose_q;
    pend_pt_d = pend_pt | score_evt;
    pend_ls_d = pend_ls | miss_evt;
    ld        = 1'b0;
    ld_val    = '0;
    go_idle   = 1'b0;

    case (state)
      IDLE: go_idle = 1'b1;
      POINT, LOSE: begin
        if (done) begin
          point_d = '0;
          lose_d  = '0;
          // With no gap the next tone starts on the very edge this one ends.
          if (GAP_CYCLES == 0) begin
            go_idle = 1'b1;
          end else begin
            state_d = GAP;
            ld      = 1'b1;
            ld_val  = GAP_LD;
          end
        end
      end
      GAP: if (done) go_idle = 1'b1;
      default: state_d = IDLE;
    endcase

    // Pending latches already include this cycle's events.
    if (go_idle) begin
      if (pend_pt_d != '0) begin
        state_d   = POINT;
        point_d   = pend_pt_d;
        lose_d    = '0;
        pend_pt_d = '0;
        ld        = 1'b1;
        ld_val    = PT_LD;
      end else if (pend_ls_d != '0) begin
        state_d   = LOSE;
        lose_d    = pend_ls_d;
        point_d   = '0;
        pend_ls_d = '0;
        ld        = 1'b1;
        ld_val    = LS_LD;
      end else begin
        state_d = IDLE;
      end
    end
  end

  assign point = point_q;
  assign lose  = lose_q;
  assign busy  = (state != IDLE) | (pend_pt != '0) | (pend_ls != '0);

endmodule

// File: doc/sound_event_seq.md
Name: sound_event_seq

Overview:
- Generates the `point[1:0]` / `lose[1:0]` tone-request codes consumed by the speaker tone generator.
- Converts single-cycle game events from the Pong game FSM into timed tone requests: a fixed-length point chirp, an optional silent gap, then a lose tone.
- Latches events that arrive while a tone is playing.
- Never drives `point` and `lose` non-zero at the same time.
- Sits between the game/scoring logic and the speaker tone generator, all in the `clk25` domain.

Parameters:
- POINT_CYCLES, 3125000, point tone duration in `clk25` cycles (125 ms); must be ≥1
- LOSE_CYCLES, 12500000, lose tone duration in `clk25` cycles (500 ms); must be ≥1
- GAP_CYCLES, 1250000, silence between consecutive tones in `clk25` cycles (50 ms); 0 = no gap
- CNT_W, 24, duration counter width; must hold max(POINT_CYCLES, LOSE_CYCLES, GAP_CYCLES)

Ports:
- clk25  input  1  25 MHz system clock
- rst_n  input  1  asynchronous active-low reset
- score_evt  input  2  one-cycle pulse; bit0 = player 1 scored, bit1 = player 2 scored
- miss_evt  input  2  one-cycle pulse; bit0 = player 1 missed ball, bit1 = player 2 missed ball
- point  output  2  tone request to speaker; non-zero = point chirp active; value = player code
- lose  output  2  tone request to speaker; non-zero = lose tone active; value = player code
- busy  output  1  high whenever state ≠ IDLE or any pending latch is set

Behaviour:
- Reset (async, `rst_n` = 0):
  - state = IDLE; counter = 0; pend_pt = pend_ls = 0
  - point = lose = busy = 0, held for the whole time reset is asserted
  - Reset mid-tone aborts the tone immediately and discards pending events.
- Event capture, every cycle, in any state:
  - `pend_pt <= pend_pt | score_evt`; `pend_ls <= pend_ls | miss_evt`
  - Latches are one-deep per class: repeated events OR into the same latch and are not counted.
- States: IDLE, POINT, GAP, LOSE.
- IDLE:
  - If `pend_pt != 0` or `score_evt != 0`: go to POINT.
    - On the entry edge, load `point_q <= pend_pt | score_evt`, clear pend_pt, counter = POINT_CYCLES-1.
  - Else if `pend_ls != 0` or `miss_evt != 0`: go to LOSE the same way with LOSE_CYCLES-1.
  - Point has priority over lose.
  - Latency: an event seen at edge N drives the output from edge N+1 (registered output, one cycle).
- POINT / LOSE:
  - The output register holds its code; counter decrements by 1 per cycle.
  - At counter = 0: clear the output register.
    - If GAP_CYCLES = 0, take the IDLE decision directly, so back-to-back tones have no zero cycle between them.
    - Otherwise go to GAP with counter = GAP_CYCLES-1.
- GAP:
  - point = lose = 0; counter decrements.
  - At counter = 0: apply the IDLE decision; go to IDLE if nothing is pending.
- Retrigger rule:
  - A new score_evt during POINT does not restart or extend the tone.
  - It is latched and played after the gap.
- Simultaneous score_evt and miss_evt (normal miss scenario): sequence is POINT → GAP → LOSE.
- Outputs:
  - Driven from registers only, with no combinational path from inputs.
  - Exactly one of point/lose is non-zero in POINT/LOSE; both are zero in IDLE/GAP.
- busy = (state ≠ IDLE) | (pend_pt ≠ 0) | (pend_ls ≠ 0), registered-state based.
- Counter arithmetic:
  - Unsigned, CNT_W bits.
  - Loaded with DURATION-1 and never decremented below 0.
  - No wrap is possible.

Decomposition:
- Shared package `sound_pkg`:
  - state encoding enum (IDLE=0, POINT=1, GAP=2, LOSE=3)
  - default duration constants (POINT_CYCLES, LOSE_CYCLES, GAP_CYCLES)
  - player code constants P1=2'b01, P2=2'b10
- One natural sub-module, `sound_dur_timer`: loadable down-counter with a `load`/`value` input and a `done` output (counter = 0), CNT_W wide.
- The FSM and pending latches stay in the top module.

Test Plan (bench overrides POINT_CYCLES=8, LOSE_CYCLES=16, GAP_CYCLES=3):
- Reset mid-tone: pulse score_evt=01, then drop rst_n after 4 cycles → point=00, lose=00, busy=0 immediately (asynchronous); after release, stays IDLE with no replayed tone.
- Single score: score_evt=01 at cycle 0 → point=01 for exactly cycles 1–8, then 0; lose stays 00; busy falls after the 3 gap cycles.
- Miss with score: score_evt=10 and miss_evt=01 in the same cycle → point=10 for 8 cycles, 3 zero cycles, lose=01 for 16 cycles, then IDLE; point and lose are never both non-zero.
- Event during tone: score_evt=01 at cycle 0, score_evt=10 at cycle 4 → first chirp point=01 is not extended (8 cycles), gap of 3, then point=10 for 8 cycles.
- Zero gap: rebuild with GAP_CYCLES=0 and a pending lose during POINT → lose asserts on the cycle immediately after point drops, with no idle cycle between.
- Latch merge: miss_evt=01 and miss_evt=10 pulsed during a point tone → single lose tone with lose=11 for 16 cycles.
